// File: rtl/stream_loopback_fifo.sv
// Byte-stream buffer between a UART receiver and transmitter: block-RAM FIFO with a
// registered valid/ready output stage, run modes, hysteretic high-water flag and statistics.
`timescale 1ns/1ps
module stream_loopback_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned HI_WM  = DEPTH - 16,
  parameter int unsigned LO_WM  = DEPTH / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [1:0]        mode,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [15:0]       rx_total,
  output logic [15:0]       tx_total,
  output logic [15:0]       drop_total,
  output logic [15:0]       ovf_total
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [1:0] M_PASS  = 2'b00;
  localparam logic [1:0] M_DRAIN = 2'b10;
  localparam logic [1:0] M_FLUSH = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [DATA_W-1:0] r_rd_data, r_out_data;
  logic              r_out_valid, r_drain;
  logic [CNT_W-1:0]  r_count;
  logic              r_empty, r_full, r_almost_full;
  logic [15:0]       r_rx_total, r_tx_total, r_drop_total, r_ovf_total;

  logic              w_flush, w_pass, w_wr, w_tx, w_drop, w_pop, w_mem_has;
  logic [CNT_W-1:0]  w_mem_cnt, w_cnt_nx;

  // Words still in memory exclude the one in flight (FETCH) or in the output register (VALID).
  assign w_flush   = (mode == M_FLUSH);
  assign w_pass    = (mode == M_PASS);
  assign w_wr      = in_valid && !w_flush && !r_full;
  assign w_tx      = (r_state == S_VALID) && r_out_valid && out_ready;
  assign w_drop    = (r_state == S_VALID) && r_drain;
  assign w_pop     = w_tx || w_drop;
  assign w_mem_cnt = r_count - CNT_W'(r_state != S_IDLE);
  assign w_mem_has = (w_mem_cnt != '0);
  assign w_cnt_nx  = w_flush ? '0 : r_count + CNT_W'(w_wr) - CNT_W'(w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= in_data;
  end

  // Output stage FSM; a pop in VALID with memory data reloads directly to hold one word per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rd_data   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_drain     <= 1'b0;
    end else if (w_flush) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rd_data   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_drain     <= 1'b0;
    end else begin
      r_drain <= (mode == M_DRAIN);
      if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      case (r_state)
        S_IDLE: begin
          r_out_valid <= 1'b0;
          if (w_mem_has) begin
            r_rd_data <= r_mem[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_out_data  <= r_rd_data;
          r_out_valid <= w_pass;
          r_state     <= S_VALID;
        end
        S_VALID: begin
          if (w_pop && !w_mem_has) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_out_valid <= w_pass;
            if (w_pop) begin
              r_out_data <= r_mem[r_rd_ptr];
              r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Occupancy, flags and statistics; flags derive from the next count so all agree each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count       <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_rx_total    <= '0;
      r_tx_total    <= '0;
      r_drop_total  <= '0;
      r_ovf_total   <= '0;
    end else begin
      r_count <= w_cnt_nx;
      r_empty <= (w_cnt_nx == '0);
      r_full  <= (w_cnt_nx == CNT_W'(DEPTH));
      if (w_cnt_nx >= CNT_W'(HI_WM))      r_almost_full <= 1'b1;
      else if (w_cnt_nx <= CNT_W'(LO_WM)) r_almost_full <= 1'b0;
      if (w_wr)   r_rx_total   <= r_rx_total + 16'd1;
      if (w_tx)   r_tx_total   <= r_tx_total + 16'd1;
      if (w_drop) r_drop_total <= r_drop_total + 16'd1;
      if (in_valid && !w_flush && r_full && (r_ovf_total != 16'hFFFF))
        r_ovf_total <= r_ovf_total + 16'd1;
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign count       = r_count;
  assign empty       = r_empty;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign wr_ptr      = r_wr_ptr;
  assign rd_ptr      = r_rd_ptr;
  assign rx_total    = r_rx_total;
  assign tx_total    = r_tx_total;
  assign drop_total  = r_drop_total;
  assign ovf_total   = r_ovf_total;

endmodule

// File: tb/tb_stream_loopback_fifo.sv
// Randomized bench for stream_loopback_fifo against a queue-based reference model.
`timescale 1ns/1ps
module tb_stream_loopback_fifo;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned HI_WM = DEPTH - 16;
  localparam int unsigned LO_WM = DEPTH / 4;
  localparam logic [1:0] PASS = 2'b00, HOLD = 2'b01, DRAIN = 2'b10, FLUSH = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] mode = PASS;
  logic [9:0] count;
  logic       empty, full, almost_full;
  logic [8:0] wr_ptr, rd_ptr;
  logic [15:0] rx_total, tx_total, drop_total, ovf_total;

  stream_loopback_fifo dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .mode(mode),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .rx_total(rx_total), .tx_total(tx_total),
    .drop_total(drop_total), .ovf_total(ovf_total)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  q[$];
  logic [15:0] rx_m, tx_m, drop_m, ovf_m;
  bit          af_m, chk_en, prev_stall;
  logic [7:0]  prev_data;
  logic [1:0]  last_mode;
  int          cyc, xfer_n, first_x, last_x;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    q.delete();
    rx_m = '0; tx_m = '0; drop_m = '0; ovf_m = '0;
    af_m = 1'b0; prev_stall = 1'b0; last_mode = PASS; chk_en = 1'b1;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = PASS;
    #1;
    check_val("rst_count", count, 0);
    check_val("rst_empty", empty, 1);
    check_val("rst_full", full, 0);
    check_val("rst_af", almost_full, 0);
    check_val("rst_ovalid", out_valid, 0);
    check_val("rst_odata", out_data, 0);
    check_val("rst_ptrs", {wr_ptr, rd_ptr}, 0);
    check_val("rst_stats", {rx_total, tx_total, drop_total, ovf_total}, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic rdy, input logic [1:0] m);
    bit xf, acc;
    logic [7:0] exp_d;
    in_valid = v; in_data = d; out_ready = rdy; mode = m;
    if (prev_stall && out_valid) check_val("stall_stable", out_data, prev_data);
    prev_stall = out_valid && !rdy;
    prev_data  = out_data;
    xf  = out_valid && rdy;
    acc = v && (m != FLUSH) && (q.size() < DEPTH);
    if (v && (m != FLUSH) && !acc && ovf_m != 16'hFFFF) ovf_m = ovf_m + 16'd1;
    if (xf) begin
      if (q.size() == 0) begin
        check_val("xfer_when_empty", out_valid, 0);
      end else begin
        exp_d = q.pop_front();
        check_val("out_data", out_data, exp_d);
      end
      tx_m = tx_m + 16'd1;
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
      xfer_n++;
    end
    if (acc) begin
      q.push_back(d);
      rx_m = rx_m + 16'd1;
    end
    if (m == FLUSH) q.delete();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    last_mode = m;
    if (q.size() >= HI_WM) af_m = 1'b1;
    else if (q.size() <= LO_WM) af_m = 1'b0;
    check_val("rx_total", rx_total, rx_m);
    check_val("tx_total", tx_total, tx_m);
    check_val("ovf_total", ovf_total, ovf_m);
    if (last_mode != PASS || (chk_en && q.size() == 0)) check_val("ovalid_gate", out_valid, 0);
    if (chk_en) begin
      check_val("count", count, q.size());
      check_val("empty", empty, q.size() == 0);
      check_val("full", full, q.size() == DEPTH);
      check_val("almost_full", almost_full, af_m);
      check_val("drop_total", drop_total, drop_m);
    end
  endtask

  task automatic drain_pass(input int max_cyc);
    int n = 0;
    while (q.size() != 0 && n < max_cyc) begin
      cycle(1'b0, 8'h00, 1'b1, PASS);
      n++;
    end
    check_val("drain_done", q.size(), 0);
  endtask

  task automatic latency_check(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, PASS);
    check_val("lat_k", out_valid, 0);
    cycle(1'b0, 8'h00, 1'b0, PASS);
    check_val("lat_k1", out_valid, 0);
    cycle(1'b0, 8'h00, 1'b0, PASS);
    check_val("lat_k2", out_valid, 1);
    check_val("lat_data", out_data, d);
    drain_pass(10);
  endtask

  initial begin
    logic [15:0] snap;
    cyc = 0; first_x = -1; last_x = -1; xfer_n = 0;
    model_clear();
    #2;
    apply_reset();
    latency_check(8'hC3);

    // Back-to-back ordered stream with the sink always ready.
    first_x = -1; xfer_n = 0;
    for (int i = 0; i < 256; i++) cycle(1'b1, 8'(i), 1'b1, PASS);
    drain_pass(20);
    check_val("thru_words", xfer_n, 256);
    check_val("thru_span", last_x - first_x, 255);
    check_val("thru_rx", rx_total, 16'd257);

    // Overflow with a stalled sink, watching the high-water threshold on the way up.
    apply_reset();
    for (int i = 0; i < 520; i++) begin
      cycle(1'b1, 8'($urandom), 1'b0, PASS);
      if (q.size() == HI_WM - 1) check_val("af_495", almost_full, 0);
      if (q.size() == HI_WM && i == HI_WM - 1) check_val("af_496", almost_full, 1);
    end
    check_val("ovf_count", count, 512);
    check_val("ovf_full", full, 1);
    check_val("ovf_total8", ovf_total, 8);
    cycle(1'b1, 8'h77, 1'b1, PASS);
    check_val("full_pushpop_count", count, 511);
    check_val("full_pushpop_ovf", ovf_total, 9);

    // Hysteresis on the way down.
    for (int n = 0; q.size() > LO_WM + 1 && n < 600; n++) cycle(1'b0, 8'h00, 1'b1, PASS);
    check_val("af_129_count", count, LO_WM + 1);
    check_val("af_129", almost_full, 1);
    for (int n = 0; q.size() > LO_WM && n < 10; n++) cycle(1'b0, 8'h00, 1'b1, PASS);
    check_val("af_128", almost_full, 0);
    drain_pass(200);

    // Random backpressure with periodic HOLD windows.
    for (int i = 0; i < 1500; i++)
      cycle(($urandom % 3) != 0, 8'($urandom), 1'($urandom), ((i % 200) >= 150) ? HOLD : PASS);
    drain_pass(600);

    // DRAIN discards without touching tx_total.
    apply_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i + 16), 1'b0, PASS);
    snap = tx_total;
    chk_en = 1'b0;
    repeat (20) cycle(1'b0, 8'h00, 1'b0, DRAIN);
    drop_m = drop_m + 16'(q.size());
    q.delete();
    chk_en = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, PASS);
    check_val("drain_drop", drop_total, 10);
    check_val("drain_tx", tx_total, snap);

    // One FLUSH cycle with a write pending.
    for (int i = 0; i < 50; i++) cycle(1'b1, 8'($urandom), 1'b0, PASS);
    snap = rx_total;
    cycle(1'b1, 8'hAA, 1'b0, FLUSH);
    check_val("flush_count", count, 0);
    check_val("flush_rx", rx_total, snap);
    check_val("flush_ptrs", {wr_ptr, rd_ptr}, 0);
    cycle(1'b1, 8'h5A, 1'b0, PASS);
    drain_pass(10);

    // Reset mid-stream with 37 words held.
    for (int i = 0; i < 37; i++) cycle(1'b1, 8'($urandom), 1'b0, PASS);
    check_val("pre_rst_count", count, 37);
    apply_reset();
    latency_check(8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
